avl_sample_fifo_responder: RTL



---
 rtl/avl_sample_fifo_responder.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/avl_sample_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module   : avl_sample_fifo_responder
// Purpose  : Avalon-MM responder that buffers the 16-bit sample stream in a
//            FIFO and exposes it through a small register map, with a level
//            and overflow interrupt.
// Options  : define AVL_SAMPLE_FIFO_STATS_EN to add the saturating
//            dropped-sample counter at address 6.
// Revision : 1.0 - initial release
// ============================================================================
module avl_sample_fifo_responder #(
  parameter int          FIFO_DEPTH = 64,
  parameter logic [15:0] ID_VALUE   = 16'h5B0F
) (
  input  logic        avl_clk_i,
  input  logic        avl_reset_i,
  input  logic [13:0] avl_address_i,
  input  logic [3:0]  avl_byteenable_i,
  input  logic        avl_write_i,
  input  logic [15:0] avl_writedata_i,
  input  logic        avl_read_i,
  output logic        avl_readdatavalid_o,
  output logic [15:0] avl_readdata_o,
  output logic        avl_waitrequest_o,
  output logic        avl_irq_o,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH) + 1;
  localparam int c_idx_w = c_ptr_w - 1;

  localparam logic [13:0] c_addr_id     = 14'd0;
  localparam logic [13:0] c_addr_ctrl   = 14'd1;
  localparam logic [13:0] c_addr_status = 14'd2;
  localparam logic [13:0] c_addr_level  = 14'd3;
  localparam logic [13:0] c_addr_thr    = 14'd4;
  localparam logic [13:0] c_addr_data   = 14'd5;
  localparam logic [13:0] c_addr_drop   = 14'd6;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACK = 1'b1} wr_state_t;

  wr_state_t          r_wr_state;
  wr_state_t          w_wr_state_nxt;
  logic               w_wr_commit;

  logic [15:0]        r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_ptr_w-1:0] w_level;
  logic [15:0]        w_level16;
  logic               w_empty;
  logic               w_full;

  logic               r_acq_en;
  logic               r_irq_en;
  logic [15:0]        r_threshold;
  logic               r_overflow;
  logic               r_underflow;
  logic               r_irq;
  logic               r_rdv;
  logic [15:0]        r_rdata;
  logic [15:0]        w_rd_mux;
  logic [15:0]        w_dropped;

  logic               w_wr_ctrl;
  logic               w_wr_status;
  logic               w_wr_thr;
  logic               w_flush;
  logic               w_rd_data;
  logic               w_pop;
  logic               w_push_req;
  logic               w_push;
  logic               w_drop;
  logic               w_unused_be;

  assign w_unused_be = ^avl_byteenable_i[3:2];

  // FIFO occupancy derived from the extra-MSB pointer pair
  assign w_level   = r_wptr - r_rptr;
  assign w_level16 = 16'(w_level);
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[c_ptr_w-1] != r_rptr[c_ptr_w-1]) &&
                     (r_wptr[c_idx_w-1:0] == r_rptr[c_idx_w-1:0]);

  // Register-write decode, effective only on the ACK commit edge
  assign w_wr_ctrl   = w_wr_commit && (avl_address_i == c_addr_ctrl);
  assign w_wr_status = w_wr_commit && (avl_address_i == c_addr_status);
  assign w_wr_thr    = w_wr_commit && (avl_address_i == c_addr_thr);
  assign w_flush     = w_wr_ctrl && avl_byteenable_i[0] && avl_writedata_i[2];

  // A pop only happens on a non-empty FIFO; a push may use the slot a same-cycle pop frees
  assign w_rd_data  = avl_read_i && (avl_address_i == c_addr_data);
  assign w_pop      = w_rd_data && !w_empty;
  assign w_push_req = sample_valid_i && r_acq_en;
  assign w_push     = w_push_req && (!w_full || w_pop) && !w_flush;
  assign w_drop     = w_push_req && w_full && !w_pop;

  // Write FSM state register
  always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
    if (!avl_reset_i) r_wr_state <= ST_IDLE;
    else              r_wr_state <= w_wr_state_nxt;
  end

  // Write FSM: stall one cycle in IDLE, commit in ACK
  always_comb begin
    w_wr_state_nxt    = r_wr_state;
    avl_waitrequest_o = 1'b0;
    w_wr_commit       = 1'b0;
    case (r_wr_state)
      ST_IDLE: begin
        avl_waitrequest_o = avl_write_i;
        if (avl_write_i) w_wr_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        w_wr_commit    = avl_write_i;
        w_wr_state_nxt = ST_IDLE;
      end
      default: w_wr_state_nxt = ST_IDLE;
    endcase
  end

  // Sample storage, no reset needed on the data array
  always_ff @(posedge avl_clk_i) begin
    if (w_push) r_mem[r_wptr[c_idx_w-1:0]] <= sample_i;
  end

  // FIFO pointers; flush discards both contents and any same-edge push
  always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
    if (!avl_reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Control, threshold and sticky status flags (a new event wins over its W1C)
  always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
    if (!avl_reset_i) begin
      r_acq_en    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_threshold <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ctrl && avl_byteenable_i[0]) begin
        r_acq_en <= avl_writedata_i[0];
        r_irq_en <= avl_writedata_i[1];
      end
      if (w_wr_thr && avl_byteenable_i[0]) r_threshold[7:0]  <= avl_writedata_i[7:0];
      if (w_wr_thr && avl_byteenable_i[1]) r_threshold[15:8] <= avl_writedata_i[15:8];
      if (w_drop)
        r_overflow <= 1'b1;
      else if (w_wr_status && avl_byteenable_i[0] && avl_writedata_i[2])
        r_overflow <= 1'b0;
      if (w_rd_data && w_empty)
        r_underflow <= 1'b1;
      else if (w_wr_status && avl_byteenable_i[0] && avl_writedata_i[3])
        r_underflow <= 1'b0;
    end
  end

  // Level interrupt, registered from the current FIFO level and overflow flag
  always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
    if (!avl_reset_i) r_irq <= 1'b0;
    else r_irq <= r_irq_en && (((r_threshold != 16'd0) && (w_level16 >= r_threshold)) ||
                               r_overflow);
  end

`ifdef AVL_SAMPLE_FIFO_STATS_EN
  logic [15:0] r_dropped;

  // Saturating count of samples lost to a full FIFO; any write to it clears
  always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
    if (!avl_reset_i)
      r_dropped <= '0;
    else if (w_wr_commit && (avl_address_i == c_addr_drop))
      r_dropped <= '0;
    else if (w_drop && (r_dropped != 16'hFFFF))
      r_dropped <= r_dropped + 16'd1;
  end

  assign w_dropped = r_dropped;
`else
  assign w_dropped = '0;
`endif

  // Read data selection
  always_comb begin
    w_rd_mux = '0;
    case (avl_address_i)
      c_addr_id:     w_rd_mux = ID_VALUE;
      c_addr_ctrl:   w_rd_mux = {14'd0, r_irq_en, r_acq_en};
      c_addr_status: w_rd_mux = {11'd0, r_irq, r_underflow, r_overflow, w_full, w_empty};
      c_addr_level:  w_rd_mux = w_level16;
      c_addr_thr:    w_rd_mux = r_threshold;
      c_addr_data:   w_rd_mux = w_empty ? 16'd0 : r_mem[r_rptr[c_idx_w-1:0]];
      c_addr_drop:   w_rd_mux = w_dropped;
      default:       w_rd_mux = '0;
    endcase
  end

  // Fixed one-cycle read response; data is forced to zero outside the valid cycle
  always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
    if (!avl_reset_i) begin
      r_rdv   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_rdv   <= avl_read_i;
      r_rdata <= avl_read_i ? w_rd_mux : 16'd0;
    end
  end

  assign avl_readdatavalid_o = r_rdv;
  assign avl_readdata_o      = r_rdata;
  assign avl_irq_o           = r_irq;

endmodule
`default_nettype wire
